multdiv_issue_ctrl: RTL and testbench



---
 rtl/multdiv_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - launches one mult/div operation, stalls until ready, delivers one writeback
// Optional saturating stall-cycle counter enabled by `define MULTDIV_PERF_COUNT_EN.
module multdiv_issue_ctrl #(
  parameter int unsigned RSTATUS_REG   = 30,
  parameter int unsigned MULT_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE  = 5,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [31:0] issue_rs,
  input  logic [31:0] issue_rt,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] perf_stall_cycles
);

  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        op_q;
  logic [4:0]  rd_q;
  logic [7:0]  tmo_cnt;
  logic        mult_q, div_q;
  logic        accept, capture, timed_out;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        stall = issue_valid;
        if (issue_valid && !flush) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        // Ready is not looked at here: it may still be the previous operation's.
        stall     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (data_resultRDY) begin
          capture   = 1'b1;
          state_nxt = WB;
        end else if (tmo_cnt == TMO_LAST) begin
          capture   = 1'b1;
          timed_out = 1'b1;
          state_nxt = WB;
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      op_q          <= 1'b0;
      rd_q          <= '0;
      data_operandA <= '0;
      data_operandB <= '0;
      mult_q        <= 1'b0;
      div_q         <= 1'b0;
      tmo_cnt       <= '0;
      wb_rd         <= '0;
      wb_data       <= '0;
    end else begin
      state  <= state_nxt;
      mult_q <= accept & ~issue_op;
      div_q  <= accept & issue_op;
      if (accept) begin
        op_q          <= issue_op;
        rd_q          <= issue_rd;
        data_operandA <= issue_rs;
        data_operandB <= issue_rt;
      end
      if (state == START) begin
        tmo_cnt <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (capture) begin
        if (timed_out || data_exception) begin
          wb_rd   <= 5'(RSTATUS_REG);
          wb_data <= op_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
        end else begin
          wb_rd   <= rd_q;
          wb_data <= data_result;
        end
      end
    end
  end

  // A flush in the same cycle squashes the start pulse and the write enable.
  assign ctrl_MULT = mult_q & ~flush;
  assign ctrl_DIV  = div_q & ~flush;
  assign wb_valid  = (state == WB) && (wb_rd != 5'd0) && !flush;

`ifdef MULTDIV_PERF_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cycles <= '0;
    end else if (stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - self-checking bench for multdiv_issue_ctrl
module tb_multdiv_issue_ctrl;

  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1000000;
`ifdef MULTDIV_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid, issue_op, flush;
  logic [31:0] issue_rs, issue_rt;
  logic [4:0]  issue_rd;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, perf_stall_cycles;

  int checks   = 0;
  int failures = 0;
  int exp_perf = 0;

  multdiv_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rs(issue_rs),
    .issue_rt(issue_rt), .issue_rd(issue_rd), .flush(flush),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          lat;      // ready this many cycles after the start pulse; 0 = never
    logic        exc;
    int          cf;       // flush cycle relative to issue; -1 = none
    logic        stale;
    int          tail;
    logic        chk_data;
    logic [4:0]  x_rd;
    logic [31:0] x_data;
    int          x_wbs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0d: actual=0x%0h required=0x%0h", nm, c, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input int lat, input logic exc, input int cf,
                     input logic stale, input int tail, input logic chk_data,
                     input logic [4:0] x_rd, input logic [31:0] x_data, input int x_wbs);
    vec_t v;
    v.name = nm; v.op = op; v.a = a; v.b = b; v.rd = rd; v.lat = lat; v.exc = exc;
    v.cf = cf; v.stale = stale; v.tail = tail; v.chk_data = chk_data;
    v.x_rd = x_rd; v.x_data = x_data; v.x_wbs = x_wbs;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] mdu_result(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (op) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    return a * b;
  endfunction

  // Cycle (issue = 0) in which the writeback is presented.
  function automatic int wb_cycle(input int lat);
    int c_rdy;
    c_rdy = (lat > 0) ? 1 + lat : NEVER;
    return ((c_rdy > 1 + TIMEOUT) ? 1 + TIMEOUT : c_rdy) + 1;
  endfunction

  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input logic exc, input int cf,
                        input logic stale, input int tail,
                        output int obs_wbs, output logic [4:0] obs_rd, output logic [31:0] obs_data);
    int          c_rdy, c_wb, last, n;
    logic        exc_path, e_stall, e_pulse, e_wbv;
    logic [4:0]  tgt;
    logic [31:0] res;
    c_rdy    = (lat > 0) ? 1 + lat : NEVER;
    c_wb     = wb_cycle(lat);
    exc_path = (c_rdy >= c_wb) || exc;
    tgt      = exc_path ? 5'd30 : rd;
    res      = mdu_result(op, a, b);
    last     = (cf >= 0 && cf <= c_wb) ? cf : c_wb;
    n        = last + tail;
    if (c_rdy != NEVER && c_rdy + 1 > n) n = c_rdy + 1;
    obs_wbs  = 0;
    obs_rd   = '0;
    obs_data = '0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clock);
      issue_valid    = (c <= last);
      issue_op       = (c <= last) ? op : 1'($urandom);
      issue_rs       = (c <= last) ? a : $urandom;
      issue_rt       = (c <= last) ? b : $urandom;
      issue_rd       = (c <= last) ? rd : 5'($urandom);
      flush          = (c == cf);
      data_resultRDY = (c == c_rdy) || (stale && c <= 1);
      data_result    = (c == c_rdy) ? res : $urandom;
      data_exception = (c == c_rdy) ? exc : (stale && c <= 1);
      #1;
      e_stall = (c == 0) || (c <= last && c < c_wb);
      e_pulse = (c == 1) && (c <= last) && (c != cf);
      e_wbv   = (c == c_wb) && (c <= last) && (c != cf) && (tgt != 5'd0);
      chk("stall", c, 32'(stall), 32'(e_stall));
      chk("ctrl_MULT", c, 32'(ctrl_MULT), 32'(e_pulse && !op));
      chk("ctrl_DIV", c, 32'(ctrl_DIV), 32'(e_pulse && op));
      chk("wb_valid", c, 32'(wb_valid), 32'(e_wbv));
      chk("perf_stall_cycles", c, perf_stall_cycles, PERF ? 32'(exp_perf) : 32'd0);
      if (c >= 1 && c <= last) begin
        chk("data_operandA", c, data_operandA, a);
        chk("data_operandB", c, data_operandB, b);
      end
      if (wb_valid) obs_wbs++;
      if (c == c_wb && c <= last && c != cf) begin
        obs_rd   = wb_rd;
        obs_data = wb_data;
      end
      if (e_stall) exp_perf++;
    end
  endtask

  initial begin
    int          ov;
    logic [4:0]  orr;
    logic [31:0] od;

    reset_n = 1'b0; issue_valid = 1'b0; issue_op = 1'b0; issue_rs = '0; issue_rt = '0;
    issue_rd = '0; flush = 1'b0; data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset.stall", 0, 32'(stall), 32'd0);
    chk("reset.ctrl_MULT", 0, 32'(ctrl_MULT), 32'd0);
    chk("reset.ctrl_DIV", 0, 32'(ctrl_DIV), 32'd0);
    chk("reset.wb_valid", 0, 32'(wb_valid), 32'd0);
    chk("reset.operandA", 0, data_operandA, 32'd0);
    chk("reset.operandB", 0, data_operandB, 32'd0);
    chk("reset.wb_rd", 0, 32'(wb_rd), 32'd0);
    chk("reset.wb_data", 0, wb_data, 32'd0);
    chk("reset.perf", 0, perf_stall_cycles, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    //   name            op    a              b         rd     lat          exc   cf  stale tail chk  x_rd   x_data          wbs
    add("mult_7x6",      1'b0, 32'd7,         32'd6,    5'd3,  2,           1'b0, -1, 1'b0, 2, 1'b1, 5'd3,  32'd42,         1);
    add("div_100_7",     1'b1, 32'd100,       32'd7,    5'd5,  33,          1'b0, -1, 1'b0, 2, 1'b1, 5'd5,  32'd14,         1);
    add("div_by_zero",   1'b1, 32'd100,       32'd0,    5'd8,  5,           1'b1, -1, 1'b0, 2, 1'b1, 5'd30, 32'd5,          1);
    add("mult_timeout",  1'b0, 32'd5,         32'd9,    5'd9,  0,           1'b0, -1, 1'b0, 2, 1'b1, 5'd30, 32'd4,          1);
    add("flush_wait",    1'b0, 32'd3,         32'd4,    5'd4,  3,           1'b0, 3,  1'b0, 2, 1'b0, 5'd0,  32'd0,          0);
    add("stale_rd0",     1'b0, 32'd3,         32'd3,    5'd0,  3,           1'b0, -1, 1'b1, 2, 1'b1, 5'd0,  32'd9,          0);
    add("flush_start",   1'b1, 32'd50,        32'd5,    5'd10, 2,           1'b0, 1,  1'b0, 2, 1'b0, 5'd0,  32'd0,          0);
    add("flush_wb",      1'b0, 32'd2,         32'd2,    5'd11, 1,           1'b0, 3,  1'b0, 2, 1'b0, 5'd0,  32'd0,          0);
    add("flush_idle",    1'b0, 32'd2,         32'd2,    5'd12, 1,           1'b0, 0,  1'b0, 2, 1'b0, 5'd0,  32'd0,          0);
    add("rdy_last_wait", 1'b0, 32'd2,         32'd3,    5'd7,  TIMEOUT,     1'b0, -1, 1'b0, 2, 1'b1, 5'd7,  32'd6,          1);
    add("rdy_too_late",  1'b1, 32'd9,         32'd3,    5'd13, TIMEOUT + 1, 1'b0, -1, 1'b0, 2, 1'b1, 5'd30, 32'd5,          1);
    add("mult_ovf",      1'b0, 32'h1_0000,    32'h1_0000, 5'd14, 4,         1'b1, -1, 1'b0, 0, 1'b1, 5'd30, 32'd4,          1);
    add("b2b_mult",      1'b0, 32'hFFFF_FFFF, 32'd2,    5'd31, 1,           1'b0, -1, 1'b0, 0, 1'b1, 5'd31, 32'hFFFF_FFFE, 1);
    add("b2b_div",       1'b1, 32'hFFFF_FFFF, 32'd16,   5'd1,  1,           1'b0, -1, 1'b0, 2, 1'b1, 5'd1,  32'h0FFF_FFFF, 1);

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].lat, tbl[i].exc, tbl[i].cf,
             tbl[i].stale, tbl[i].tail, ov, orr, od);
      chk({tbl[i].name, ".wb_count"}, i, 32'(ov), 32'(tbl[i].x_wbs));
      if (tbl[i].chk_data) begin
        chk({tbl[i].name, ".wb_rd"}, i, 32'(orr), 32'(tbl[i].x_rd));
        chk({tbl[i].name, ".wb_data"}, i, od, tbl[i].x_data);
      end
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clock);
    issue_valid = 1'b1; issue_op = 1'b1; issue_rs = 32'd55; issue_rt = 32'd5; issue_rd = 5'd6;
    flush = 1'b0; data_resultRDY = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk("midreset.stall", 0, 32'(stall), 32'd0);
    chk("midreset.ctrl_DIV", 0, 32'(ctrl_DIV), 32'd0);
    chk("midreset.wb_valid", 0, 32'(wb_valid), 32'd0);
    chk("midreset.operandA", 0, data_operandA, 32'd0);
    chk("midreset.wb_data", 0, wb_data, 32'd0);
    chk("midreset.perf", 0, perf_stall_cycles, 32'd0);
    @(negedge clock);
    data_resultRDY = 1'b1; data_result = 32'd11;
    #1;
    chk("midreset.late_rdy", 1, 32'(wb_valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1; data_resultRDY = 1'b0;
    exp_perf = 0;

    for (int k = 0; k < 60; k++) begin
      logic        op, exc, stale, exc_path;
      logic [31:0] a, b, x_data;
      logic [4:0]  rd, x_rd;
      int          lat, cf, tail, x_wbs;
      op    = 1'($urandom);
      a     = $urandom;
      b     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom;
      rd    = 5'($urandom);
      lat   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                          : int'($urandom_range(1, 12));
      if ($urandom_range(0, 15) == 0) lat = 0;
      exc   = ($urandom_range(0, 7) == 0);
      cf    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, wb_cycle(lat))) : -1;
      stale = 1'($urandom);
      tail  = $urandom_range(0, 2);
      exc_path = exc || (lat == 0) || (lat > TIMEOUT);
      x_rd     = exc_path ? 5'd30 : rd;
      x_data   = exc_path ? (op ? 32'd5 : 32'd4) : mdu_result(op, a, b);
      x_wbs    = (cf < 0 && x_rd != 5'd0) ? 1 : 0;
      run_op(op, a, b, rd, lat, exc, cf, stale, tail, ov, orr, od);
      chk("rnd.wb_count", k, 32'(ov), 32'(x_wbs));
      if (cf < 0) begin
        chk("rnd.wb_rd", k, 32'(orr), 32'(x_rd));
        chk("rnd.wb_data", k, od, x_data);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
